// File: rtl/rb_arb_pkg.sv
// -----------------------------------------------------------------------------
// rb_arb_pkg
// Shared types and constants for the register-bank access arbiter.
//   rb_state_e : arbiter FSM states (IDLE, ACCESS, RESP)
//   RW_READ / RW_WRITE : encoding of the rw / RB_RW direction bits
//   RB_AW_DEF / RB_DW_DEF : default bank address / data widths
// -----------------------------------------------------------------------------
package rb_arb_pkg;

  localparam int RB_AW_DEF = 3;
  localparam int RB_DW_DEF = 18;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } rb_state_e;

endpackage

// File: rtl/rb_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// rb_access_arbiter_if
// Bundles the two requester handshakes, the shared read-data return and the
// single-port register bank controls.
//   Requester n (n = 0,1): reqn, rwn, addrn, wdatan -> arbiter; gntn, rvalidn <- arbiter
//   rdata, busy            : arbiter -> requesters
//   RB_RW, RB_A, RB_D      : arbiter -> bank
//   RB_Q                   : bank -> arbiter
// Modports: slave = arbiter side, master = requester/bank side.
// -----------------------------------------------------------------------------
interface rb_access_arbiter_if
  import rb_arb_pkg::*;
#(
  parameter int AW = RB_AW_DEF,
  parameter int DW = RB_DW_DEF
) ();

  logic          req0;
  logic          rw0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;

  logic          req1;
  logic          rw1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;

  logic [DW-1:0] rdata;
  logic          busy;

  logic          RB_RW;
  logic [AW-1:0] RB_A;
  logic [DW-1:0] RB_D;
  logic [DW-1:0] RB_Q;

  modport slave (
    input  req0, rw0, addr0, wdata0,
    input  req1, rw1, addr1, wdata1,
    input  RB_Q,
    output gnt0, rvalid0, gnt1, rvalid1,
    output rdata, busy,
    output RB_RW, RB_A, RB_D
  );

  modport master (
    output req0, rw0, addr0, wdata0,
    output req1, rw1, addr1, wdata1,
    output RB_Q,
    input  gnt0, rvalid0, gnt1, rvalid1,
    input  rdata, busy,
    input  RB_RW, RB_A, RB_D
  );

endinterface

// File: rtl/rb_rr_pick.sv
// -----------------------------------------------------------------------------
// rb_rr_pick
// Combinational two-way picker.
//   req0, req1 : pending requests
//   last       : index granted most recently (round-robin build only)
//   win        : index of the winning requester
//   vld        : at least one request is pending
// Build option: RB_ARB_FIXED_PRIO_EN -> requester 0 always wins a tie and the
// last-grant input does not exist.
// -----------------------------------------------------------------------------
module rb_rr_pick (
  input  logic req0,
  input  logic req1,
`ifndef RB_ARB_FIXED_PRIO_EN
  input  logic last,
`endif
  output logic win,
  output logic vld
);

  // Winner selection; a tie goes to the requester not granted last.
  always_comb begin
    win = 1'b0;
    vld = req0 | req1;
    if (req0 && req1) begin
`ifdef RB_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~last;
`endif
    end else if (req1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

endmodule

// File: rtl/rb_access_arbiter.sv
// -----------------------------------------------------------------------------
// rb_access_arbiter
// Shares one single-port register bank between two requesters, one access in
// flight at a time. All outputs are registered.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : rb_access_arbiter_if.slave (requester handshakes, rdata, busy,
//              bank controls RB_RW/RB_A/RB_D, bank read data RB_Q)
// Timing: arbitration in IDLE or RESP, bank cycle in ACCESS (gnt high), read
// data returned in RESP (rvalid high). RB_Q is sampled at the clock edge that
// closes ACCESS, i.e. the bank read data for RB_A presented during ACCESS.
// Build option: RB_ARB_FIXED_PRIO_EN -> fixed priority to requester 0, no
// last-grant pointer.
// -----------------------------------------------------------------------------
module rb_access_arbiter
  import rb_arb_pkg::*;
#(
  parameter int AW = RB_AW_DEF,
  parameter int DW = RB_DW_DEF
) (
  input logic              clk,
  input logic              rst,
  rb_access_arbiter_if.slave bus
);

  rb_state_e     state_r, next_state_s;

  logic          rb_rw_r,   rb_rw_s;
  logic [AW-1:0] rb_a_r,    rb_a_s;
  logic [DW-1:0] rb_d_r,    rb_d_s;
  logic          gnt0_r,    gnt0_s;
  logic          gnt1_r,    gnt1_s;
  logic          rvalid0_r, rvalid0_s;
  logic          rvalid1_r, rvalid1_s;
  logic [DW-1:0] rdata_r,   rdata_s;
  logic          busy_r,    busy_s;
  logic          owner_r,   owner_s;   // requester served by the access in flight

`ifndef RB_ARB_FIXED_PRIO_EN
  logic          last_r,    last_s;    // index granted most recently
`endif

  logic          pick_win_s;
  logic          pick_vld_s;
  logic          arb_go_s;

  rb_rr_pick u_pick (
    .req0 (bus.req0),
    .req1 (bus.req1),
`ifndef RB_ARB_FIXED_PRIO_EN
    .last (last_r),
`endif
    .win  (pick_win_s),
    .vld  (pick_vld_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    next_state_s = state_r;
    rb_rw_s      = RW_READ;
    rb_a_s       = rb_a_r;
    rb_d_s       = rb_d_r;
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    rvalid0_s    = 1'b0;
    rvalid1_s    = 1'b0;
    rdata_s      = rdata_r;
    busy_s       = 1'b0;
    owner_s      = owner_r;
`ifndef RB_ARB_FIXED_PRIO_EN
    last_s       = last_r;
`endif
    arb_go_s     = 1'b0;

    case (state_r)
      IDLE: begin
        arb_go_s = 1'b1;
      end
      ACCESS: begin
        if (rb_rw_r == RW_WRITE) begin
          next_state_s = IDLE;
        end else begin
          // Read: bank data for the presented address is taken now so it is
          // registered and valid together with rvalid in RESP.
          next_state_s = RESP;
          busy_s       = 1'b1;
          rdata_s      = bus.RB_Q;
          if (owner_r) begin
            rvalid1_s = 1'b1;
          end else begin
            rvalid0_s = 1'b1;
          end
        end
      end
      RESP: begin
        arb_go_s = 1'b1;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase

    // RESP overlaps the next arbitration, giving one access per two cycles.
    if (arb_go_s) begin
      if (pick_vld_s) begin
        next_state_s = ACCESS;
        busy_s       = 1'b1;
        owner_s      = pick_win_s;
`ifndef RB_ARB_FIXED_PRIO_EN
        last_s       = pick_win_s;
`endif
        if (pick_win_s) begin
          rb_rw_s = bus.rw1;
          rb_a_s  = bus.addr1;
          rb_d_s  = bus.wdata1;
          gnt1_s  = 1'b1;
        end else begin
          rb_rw_s = bus.rw0;
          rb_a_s  = bus.addr0;
          rb_d_s  = bus.wdata0;
          gnt0_s  = 1'b1;
        end
      end else begin
        next_state_s = IDLE;
      end
    end else begin
      owner_s = owner_r;
    end
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      rb_rw_r   <= RW_READ;
      rb_a_r    <= {AW{1'b0}};
      rb_d_r    <= {DW{1'b0}};
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      rdata_r   <= {DW{1'b0}};
      busy_r    <= 1'b0;
      owner_r   <= 1'b0;
`ifndef RB_ARB_FIXED_PRIO_EN
      last_r    <= 1'b1;
`endif
    end else begin
      state_r   <= next_state_s;
      rb_rw_r   <= rb_rw_s;
      rb_a_r    <= rb_a_s;
      rb_d_r    <= rb_d_s;
      gnt0_r    <= gnt0_s;
      gnt1_r    <= gnt1_s;
      rvalid0_r <= rvalid0_s;
      rvalid1_r <= rvalid1_s;
      rdata_r   <= rdata_s;
      busy_r    <= busy_s;
      owner_r   <= owner_s;
`ifndef RB_ARB_FIXED_PRIO_EN
      last_r    <= last_s;
`endif
    end
  end

  assign bus.RB_RW   = rb_rw_r;
  assign bus.RB_A    = rb_a_r;
  assign bus.RB_D    = rb_d_r;
  assign bus.gnt0    = gnt0_r;
  assign bus.gnt1    = gnt1_r;
  assign bus.rvalid0 = rvalid0_r;
  assign bus.rvalid1 = rvalid1_r;
  assign bus.rdata   = rdata_r;
  assign bus.busy    = busy_r;

endmodule
